// File: rtl/bus_master_pkg.sv
// Shared definitions for the bus_master burst initiator.
//   - bus width defaults for the 8-bit CPU-side memory bus
//   - burst length encoding (cmd_len holds beats minus one)
//   - FSM state encoding, also exported on the state_dbg port
package bus_master_pkg;

    localparam int BUS_ADDR_W = 8;
    localparam int BUS_DATA_W = 8;
    localparam int LEN_W      = 8;

    // Number of beats in a burst is cmd_len + LEN_OFFSET (0..255 -> 1..256).
    localparam int LEN_OFFSET = 1;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WR       = 2'd1,
        ST_RD_ISSUE = 2'd2,
        ST_RD_OUT   = 2'd3
    } state_t;

    // True when the beat being handled is the final beat of the burst.
    function automatic logic is_last_beat(input logic [LEN_W-1:0] remaining);
        return remaining == '0;
    endfunction

endpackage

// File: rtl/bus_master.sv
// bus_master: burst initiator for the 8-bit CPU-side memory bus.
//
// Accepts a burst command (direction, start address, beats-minus-one), then
// issues one single-cycle wr_en or rd_en strobe per beat, moving data in from
// the write stream or out to the read stream.
//
// Ports:
//   clk, reset              clock; asynchronous active-high reset
//   cmd_valid/cmd_ready     command handshake; cmd_write, cmd_addr, cmd_len
//   wdata/wvalid/wready     write stream into the master
//   rdata/rvalid/rready     read stream out of the master
//   done                    one-cycle pulse at burst completion
//   busy                    high whenever the FSM is not idle
//   addr/dout/din           bus address, write data, read data (din is
//                           combinational from the slave)
//   wr_en/rd_en             bus strobes, never high together
//   state_dbg               current FSM state (bus_master_pkg::state_t)
//
// Handshake rule for all three streams: a transfer happens on the rising
// edge where both valid and ready are high; valid never waits on ready, and
// the producer holds its payload stable while valid is high and ready is low.
module bus_master
    import bus_master_pkg::*;
#(
    parameter int ADDR_W = BUS_ADDR_W,
    parameter int DATA_W = BUS_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic [DATA_W-1:0] wdata,
    input  logic              wvalid,
    output logic              wready,
    output logic [DATA_W-1:0] rdata,
    output logic              rvalid,
    input  logic              rready,
    output logic              done,
    output logic              busy,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] dout,
    input  logic [DATA_W-1:0] din,
    output logic              wr_en,
    output logic              rd_en,
    output logic [1:0]        state_dbg
);

    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [LEN_W-1:0]  LEN_ONE  = {{(LEN_W-1){1'b0}}, 1'b1};

    state_t             state;
    logic [ADDR_W-1:0]  cur_addr;
    logic [LEN_W-1:0]   remaining;

    assign cmd_ready = (state == ST_IDLE);
    assign wready    = (state == ST_WR);
    assign busy      = (state != ST_IDLE);
    assign state_dbg = state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            cur_addr  <= '0;
            remaining <= '0;
            addr      <= '0;
            dout      <= '0;
            rdata     <= '0;
            rvalid    <= 1'b0;
            wr_en     <= 1'b0;
            rd_en     <= 1'b0;
            done      <= 1'b0;
        end else begin
            // Strobes and done are single-cycle unless re-asserted below.
            wr_en <= 1'b0;
            rd_en <= 1'b0;
            done  <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        cur_addr  <= cmd_addr;
                        remaining <= cmd_len;
                        if (cmd_write) begin
                            state <= ST_WR;
                        end else begin
                            // First read strobe goes out in the cycle right
                            // after acceptance.
                            state <= ST_RD_ISSUE;
                            addr  <= cmd_addr;
                            rd_en <= 1'b1;
                        end
                    end
                end

                ST_WR: begin
                    if (wvalid) begin
                        wr_en    <= 1'b1;
                        addr     <= cur_addr;
                        dout     <= wdata;
                        cur_addr <= cur_addr + ADDR_ONE;
                        if (is_last_beat(remaining)) begin
                            // done lands in the same cycle as the final wr_en.
                            state <= ST_IDLE;
                            done  <= 1'b1;
                        end else begin
                            remaining <= remaining - LEN_ONE;
                        end
                    end
                end

                ST_RD_ISSUE: begin
                    // din is valid during the rd_en cycle; capture it here.
                    rdata  <= din;
                    rvalid <= 1'b1;
                    state  <= ST_RD_OUT;
                end

                ST_RD_OUT: begin
                    if (rready) begin
                        rvalid   <= 1'b0;
                        cur_addr <= cur_addr + ADDR_ONE;
                        if (is_last_beat(remaining)) begin
                            state <= ST_IDLE;
                            done  <= 1'b1;
                        end else begin
                            remaining <= remaining - LEN_ONE;
                            state     <= ST_RD_ISSUE;
                            addr      <= cur_addr + ADDR_ONE;
                            rd_en     <= 1'b1;
                        end
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bus_master.sv
// Testbench for bus_master: directed and random bursts against a simple
// RAM slave, with a scoreboard of expected bus writes, read strobes and
// read-stream data built from a shadow memory model.
module tb_bus_master;

    logic       clk;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_write;
    logic [7:0] cmd_addr;
    logic [7:0] cmd_len;
    logic [7:0] wdata;
    logic       wvalid;
    logic       wready;
    logic [7:0] rdata;
    logic       rvalid;
    logic       rready;
    logic       done;
    logic       busy;
    logic [7:0] addr;
    logic [7:0] dout;
    logic [7:0] din;
    logic       wr_en;
    logic       rd_en;
    logic [1:0] state_dbg;

    bus_master #(.ADDR_W(8), .DATA_W(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_len   (cmd_len),
        .wdata     (wdata),
        .wvalid    (wvalid),
        .wready    (wready),
        .rdata     (rdata),
        .rvalid    (rvalid),
        .rready    (rready),
        .done      (done),
        .busy      (busy),
        .addr      (addr),
        .dout      (dout),
        .din       (din),
        .wr_en     (wr_en),
        .rd_en     (rd_en),
        .state_dbg (state_dbg)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- RAM slave ----------------
    logic [7:0] mem [256];
    assign din = mem[addr];
    always @(posedge clk) begin
        if (wr_en) mem[addr] <= dout;
    end

    // ---------------- reference model + scoreboard ----------------
    logic [7:0]  ref_mem [256];
    logic [7:0]  wbuf [256];
    logic [16:0] exp_wr_q[$];     // {last, addr, data}
    logic [7:0]  exp_rdaddr_q[$]; // address of each expected rd_en
    logic [8:0]  exp_rdata_q[$];  // {last, data}

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    // ---------------- monitor ----------------
    logic       hold_prev = 1'b0;
    logic [7:0] prev_rdata = '0;
    logic       rd_last_pending = 1'b0;

    always @(negedge clk) begin
        logic        exp_done;
        logic [16:0] we;
        logic [8:0]  re;
        logic [7:0]  ra;
        if (reset) begin
            hold_prev       = 1'b0;
            rd_last_pending = 1'b0;
        end else begin
            exp_done        = rd_last_pending;
            rd_last_pending = 1'b0;
            if (wr_en && rd_en) fail_now("strobes_both_high");
            if (wr_en) begin
                if (exp_wr_q.size() == 0) begin
                    fail_now("unexpected_wr_en");
                end else begin
                    we = exp_wr_q.pop_front();
                    chk("wr_addr", {24'd0, addr}, {24'd0, we[15:8]});
                    chk("wr_data", {24'd0, dout}, {24'd0, we[7:0]});
                    exp_done = exp_done | we[16];
                end
            end
            if (rd_en) begin
                if (exp_rdaddr_q.size() == 0) begin
                    fail_now("unexpected_rd_en");
                end else begin
                    ra = exp_rdaddr_q.pop_front();
                    chk("rd_addr", {24'd0, addr}, {24'd0, ra});
                end
            end
            if (done || exp_done) chk("done", {31'd0, done}, {31'd0, exp_done});
            if (hold_prev) begin
                chk("rvalid_held", {31'd0, rvalid}, 32'd1);
                chk("rdata_stable", {24'd0, rdata}, {24'd0, prev_rdata});
            end
            if (rvalid && rready) begin
                if (exp_rdata_q.size() == 0) begin
                    fail_now("unexpected_read_beat");
                end else begin
                    re = exp_rdata_q.pop_front();
                    chk("rdata", {24'd0, rdata}, {24'd0, re[7:0]});
                    rd_last_pending = re[8];
                end
            end
            hold_prev  = rvalid && !rready;
            prev_rdata = rdata;
        end
    end

    // ---------------- driver tasks ----------------
    // Called just after a rising edge with the DUT idle.
    task automatic issue_cmd(input logic wr, input logic [7:0] a, input logic [7:0] len);
        int cyc;
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = a;
        cmd_len   = len;
        @(negedge clk);
        chk("cmd_ready_idle", {31'd0, cmd_ready}, 32'd1);
        cyc = 0;
        while (!cmd_ready && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        chk("busy_after_accept", {31'd0, busy}, 32'd1);
    endtask

    // mode: 0 = always valid, 1 = valid pattern 1,0,0,1..., 2 = random
    task automatic write_burst(input logic [7:0] a, input logic [7:0] len, input int mode);
        int beat;
        int k;
        logic hs;
        for (int i = 0; i <= int'(len); i++) begin
            exp_wr_q.push_back({(i == int'(len)), 8'((int'(a) + i) % 256), wbuf[i]});
            ref_mem[(int'(a) + i) % 256] = wbuf[i];
        end
        issue_cmd(1'b1, a, len);
        beat = 0;
        k = 0;
        while (beat <= int'(len) && k < 3000) begin
            case (mode)
                0: wvalid = 1'b1;
                1: wvalid = (k % 3 == 0);
                default: wvalid = 1'($urandom_range(0, 1));
            endcase
            wdata = wbuf[beat];
            @(negedge clk);
            hs = wvalid && wready;
            @(posedge clk);
            #1;
            chk("wr_en_follows_hs", {31'd0, wr_en}, {31'd0, hs});
            if (hs) beat++;
            k++;
        end
        wvalid = 1'b0;
        if (beat <= int'(len)) fail_now("write_burst_timeout");
    endtask

    task automatic read_burst(input logic [7:0] a, input logic [7:0] len, input int mode);
        int beat;
        int k;
        for (int i = 0; i <= int'(len); i++) begin
            exp_rdaddr_q.push_back(8'((int'(a) + i) % 256));
            exp_rdata_q.push_back({(i == int'(len)), ref_mem[(int'(a) + i) % 256]});
        end
        issue_cmd(1'b0, a, len);
        beat = 0;
        k = 0;
        while (beat <= int'(len) && k < 3000) begin
            case (mode)
                0: rready = 1'b1;
                1: rready = (k % 3 == 0);
                default: rready = 1'($urandom_range(0, 1));
            endcase
            @(negedge clk);
            if (rvalid && rready) beat++;
            @(posedge clk);
            #1;
            k++;
        end
        rready = 1'b0;
        if (beat <= int'(len)) fail_now("read_burst_timeout");
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_addr"},   {24'd0, addr},  32'd0);
        chk({tag, "_dout"},   {24'd0, dout},  32'd0);
        chk({tag, "_rdata"},  {24'd0, rdata}, 32'd0);
        chk({tag, "_wr_en"},  {31'd0, wr_en}, 32'd0);
        chk({tag, "_rd_en"},  {31'd0, rd_en}, 32'd0);
        chk({tag, "_rvalid"}, {31'd0, rvalid}, 32'd0);
        chk({tag, "_done"},   {31'd0, done},  32'd0);
        chk({tag, "_busy"},   {31'd0, busy},  32'd0);
        chk({tag, "_wready"}, {31'd0, wready}, 32'd0);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        int hs_cnt;
        int k;
        reset     = 1'b0;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_len   = '0;
        wdata     = '0;
        wvalid    = 1'b0;
        rready    = 1'b0;

        // Asynchronous reset before any clock edge.
        #2;
        reset = 1'b1;
        #1;
        check_reset_outputs("por");
        @(posedge clk);
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk("cmd_ready_after_reset", {31'd0, cmd_ready}, 32'd1);
        chk("busy_after_reset", {31'd0, busy}, 32'd0);
        @(posedge clk);
        #1;

        // Directed write burst, wvalid held.
        wbuf[0] = 8'hAA; wbuf[1] = 8'hBB; wbuf[2] = 8'hCC; wbuf[3] = 8'hDD;
        write_burst(8'h10, 8'd3, 0);

        // Directed read burst with rready stalls.
        read_burst(8'h10, 8'd3, 1);

        // Address wrap inside a burst.
        wbuf[0] = 8'h01; wbuf[1] = 8'h02; wbuf[2] = 8'h03;
        write_burst(8'hFE, 8'd2, 0);
        chk("busy_after_wrap", {31'd0, busy}, 32'd0);
        read_burst(8'hFE, 8'd2, 0);

        // Write stream with gaps.
        wbuf[0] = 8'h5A; wbuf[1] = 8'hA5;
        write_burst(8'h30, 8'd1, 1);

        // Maximum-length burst fills all of memory with random data.
        for (int i = 0; i < 256; i++) wbuf[i] = 8'($urandom);
        write_burst(8'h00, 8'd255, 0);
        read_burst(8'h00, 8'd255, 0);

        // Random bursts.
        for (int n = 0; n < 14; n++) begin
            logic [7:0] ra;
            logic [7:0] rl;
            int md;
            ra = 8'($urandom_range(0, 255));
            rl = 8'($urandom_range(0, 15));
            md = $urandom_range(0, 2);
            if ($urandom_range(0, 1) == 1) begin
                for (int i = 0; i < 256; i++) wbuf[i] = 8'($urandom);
                write_burst(ra, rl, md);
            end else begin
                read_burst(ra, rl, md);
            end
        end

        // Reset in the middle of a read burst.
        for (int i = 0; i <= 7; i++) begin
            exp_rdaddr_q.push_back(8'((8'h40 + i) % 256));
            exp_rdata_q.push_back({(i == 7), ref_mem[(8'h40 + i) % 256]});
        end
        issue_cmd(1'b0, 8'h40, 8'd7);
        rready = 1'b1;
        hs_cnt = 0;
        k = 0;
        while (hs_cnt < 2 && k < 100) begin
            @(negedge clk);
            if (rvalid && rready) hs_cnt++;
            @(posedge clk);
            #1;
            k++;
        end
        if (hs_cnt < 2) fail_now("midreset_setup_timeout");
        rready = 1'b0;
        @(posedge clk);
        #1;
        chk("rvalid_before_reset", {31'd0, rvalid}, 32'd1);
        #1;
        reset = 1'b1;
        #1;
        check_reset_outputs("midburst");
        exp_wr_q.delete();
        exp_rdaddr_q.delete();
        exp_rdata_q.delete();
        @(posedge clk);
        #2;
        reset = 1'b0;
        // New command offered in the first cycle after release.
        wbuf[0] = 8'h77;
        write_burst(8'h50, 8'd0, 0);
        read_burst(8'h40, 8'd1, 2);

        repeat (3) @(posedge clk);
        #1;
        chk("wr_queue_empty", exp_wr_q.size(), 32'd0);
        chk("rdaddr_queue_empty", exp_rdaddr_q.size(), 32'd0);
        chk("rdata_queue_empty", exp_rdata_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bus_master.md
Name: bus_master

Overview:
Bus initiator for the 8-bit CPU-side memory bus (addr, dout, din, wr_en, rd_en) that the RAM and peripheral slaves respond to. It accepts burst commands (direction, start address, length) over a valid/ready port. It then issues the matching single-cycle write or read strobes, moving data in from a write stream or out to a read stream, each with valid/ready handshakes. It is used for debug-loader and DMA-style memory fill and dump without CPU involvement.

Parameters:
ADDR_W, 8, bus address width
DATA_W, 8, bus data width

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  asynchronous, active-high reset
cmd_valid  in  1  command offered
cmd_ready  out  1  command accepted when valid&ready
cmd_write  in  1  1 = write burst, 0 = read burst
cmd_addr  in  ADDR_W  burst start address
cmd_len  in  8  burst beats minus one (0..255 gives 1..256 beats)
wdata  in  DATA_W  write stream data
wvalid  in  1  write data offered
wready  out  1  write data accepted when wvalid&wready
rdata  out  DATA_W  read stream data
rvalid  out  1  read data valid
rready  in  1  read data consumed when rvalid&rready
done  out  1  one-cycle pulse at burst completion
busy  out  1  high in every state except IDLE
addr  out  ADDR_W  bus address
dout  out  DATA_W  bus write data (master to slave)
din  in  DATA_W  bus read data (slave to master), combinational from slave
wr_en  out  1  bus write strobe
rd_en  out  1  bus read strobe

Behaviour:
- Reset (async, immediate): state IDLE; addr, dout, rdata, wr_en, rd_en, rvalid, done, busy all 0; cur_addr and beat counter 0. Reset mid-burst drops strobes at once and discards the rest of the burst. No done pulse is produced.
- All bus outputs (addr, dout, wr_en, rd_en), rdata, rvalid and done are registered. cmd_ready = (state==IDLE). wready = (state==WR). busy = (state!=IDLE).
- States: IDLE, WR, RD_ISSUE, RD_OUT.
- IDLE: on cmd_valid, latch cur_addr=cmd_addr and remaining=cmd_len. Go to WR if cmd_write=1. Otherwise go to RD_ISSUE and, on the same edge, set addr=cmd_addr and rd_en=1.
- WR: each wvalid&wready at edge N drives wr_en=1, addr=cur_addr, dout=wdata for cycle N+1. cur_addr then increments. wr_en=0 in any cycle not following a handshake. Back-to-back wvalid gives one write per cycle. The handshake with remaining==0 returns to IDLE and sets done=1 in the same cycle as the final wr_en. Otherwise remaining decrements.
- RD_ISSUE (exactly 1 cycle): rd_en=1 with addr=cur_addr. At the exit edge, capture rdata=din, set rvalid=1, rd_en=0, and go to RD_OUT.
- RD_OUT: hold rdata and rvalid until rready.
  - On handshake: rvalid=0, cur_addr increments.
  - If remaining==0: go to IDLE and pulse done.
  - Otherwise: remaining decrements, go to RD_ISSUE with addr=cur_addr+1 and rd_en=1.
  - Maximum read throughput is one beat per 2 cycles.
- Address arithmetic is modulo 2^ADDR_W: 0xFF+1 wraps to 0x00 within a burst. The master makes no special case for address 0x00 or for unmapped addresses. An ignored write or a high-Z read is the slave's concern; rdata captures din as-is.
- In IDLE, addr and dout hold their last values; wr_en and rd_en are 0.
- A new command can be accepted in the same cycle done is high, because cmd_ready is already 1 in that cycle.
- wr_en and rd_en are never high together.

Decomposition:
- Shared header bus_master_defs: state encodings (IDLE, WR, RD_ISSUE, RD_OUT, 2 bits), bus width localparams, and the len-minus-one encoding constant.
- Single flat module; no sub-module needed.

Test Plan:
- Reset: assert reset mid-cycle with no clock -> all outputs 0 immediately. After release: cmd_ready=1, busy=0.
- Write burst: cmd_write=1, addr=0x10, len=3, wvalid held with AA,BB,CC,DD -> wr_en high 4 consecutive cycles at addr 10,11,12,13 with dout AA..DD; done high with the last wr_en.
- Read burst with stalls: read addr=0x10, len=3; rready toggles 1,0,0,1,... -> rdata AA,BB,CC,DD, each held stable while rvalid&!rready; one rd_en cycle per beat; done after the 4th handshake.
- Wrap: write addr=0xFE, len=2, data 01,02,03 -> addresses FE, FF, 00; busy returns to 0.
- Write gaps: wvalid pattern 1,0,0,1 -> wr_en exactly in the cycles following the two handshakes, 0 elsewhere.
- Reset mid-burst: apply reset during a read at beat 2 -> rd_en/rvalid drop at once, no done pulse; a new command is accepted in the first cycle after release.
